// File: rtl/dcache_pkg.sv
// dcache_pkg: FSM state type, word size and address-split width helpers for dcache.
package dcache_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESPOND} state_e;
  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(input int lines, input int line_words);
    return WORD_W - 2 - $clog2(lines) - $clog2(line_words);
  endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: core M-stage request/response plus single-word backing-memory handshake.
interface dcache_if;
  import dcache_pkg::*;
  logic              MemReadM;
  logic              MemWriteM;
  logic [WORD_W-1:0] ALUResult;
  logic [WORD_W-1:0] WriteData;
  logic [WORD_W-1:0] ReadData;
  logic              StallM;
  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;
  modport slave (
    input  MemReadM, MemWriteM, ALUResult, WriteData, mem_rdata, mem_ack,
    output ReadData, StallM, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output MemReadM, MemWriteM, ALUResult, WriteData, mem_rdata, mem_ack,
    input  ReadData, StallM, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_array.sv
// dcache_array: tag/valid/data storage with one combinational read port and one word write port.
module dcache_array import dcache_pkg::*; #(
  parameter int LINES = 16,
  parameter int LINE_WORDS = 4,
  localparam int OW = off_w(LINE_WORDS),
  localparam int IW = idx_w(LINES),
  localparam int TW = tag_w(LINES, LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IW-1:0]     rd_idx,
  input  logic [OW-1:0]     rd_off,
  output logic [WORD_W-1:0] rd_data,
  output logic [TW-1:0]     rd_tag,
  output logic              rd_valid,
  input  logic              we,
  input  logic [IW-1:0]     w_idx,
  input  logic [OW-1:0]     w_off,
  input  logic [WORD_W-1:0] w_data,
  input  logic              tv_we,
  input  logic [TW-1:0]     tv_tag,
  input  logic              tv_valid
);
  logic [WORD_W-1:0] data_q [LINES][LINE_WORDS];
  logic [TW-1:0]     tag_q [LINES];
  logic [LINES-1:0]  valid_q;
  assign rd_data  = data_q[rd_idx][rd_off];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  always_ff @(posedge clk)
    if (we) data_q[w_idx][w_off] <= w_data;
  always_ff @(posedge clk)
    if (tv_we) tag_q[w_idx] <= tv_tag;
  always_ff @(posedge clk)
    if (!reset) valid_q <= '0;
    else if (tv_we) valid_q[w_idx] <= tv_valid;
endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped write-through read-allocate data cache with refill/write-through FSM.
// Define DCACHE_PERF_EN to add the HitCount/MissCount ports and counters.
module dcache import dcache_pkg::*; #(
  parameter int LINES = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  dcache_if.slave           bus
`ifdef DCACHE_PERF_EN
  ,
  output logic [WORD_W-1:0] HitCount,
  output logic [WORD_W-1:0] MissCount
`endif
);
  localparam int OW = off_w(LINE_WORDS);
  localparam int IW = idx_w(LINES);
  localparam int TW = tag_w(LINES, LINE_WORDS);
  state_e            state_q, state_d;
  logic [OW-1:0]     cnt_q, cnt_d, w_off;
  logic [OW-1:0]     off;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     tag, rd_tag;
  logic [WORD_W-1:0] rd_data, w_data;
  logic              rd_valid, hit, stall, we, tv_we, tv_valid;
  assign off = bus.ALUResult[2 +: OW];
  assign idx = bus.ALUResult[2 + OW +: IW];
  assign tag = bus.ALUResult[WORD_W-1 -: TW];
  assign hit = rd_valid && rd_tag == tag;
  assign bus.ReadData = rd_data;
  assign bus.StallM = stall && reset;
  dcache_array #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) u_array (
    .clk(clk), .reset(reset),
    .rd_idx(idx), .rd_off(off), .rd_data(rd_data), .rd_tag(rd_tag), .rd_valid(rd_valid),
    .we(we), .w_idx(idx), .w_off(w_off), .w_data(w_data),
    .tv_we(tv_we), .tv_tag(tag), .tv_valid(tv_valid)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall         = 1'b0;
    we            = 1'b0;
    w_off         = off;
    w_data        = bus.WriteData;
    tv_we         = 1'b0;
    tv_valid      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        stall   = (bus.MemReadM && !hit) || bus.MemWriteM;
        state_d = bus.MemReadM && !hit ? REFILL : bus.MemWriteM ? WRITE : IDLE;
        cnt_d   = bus.MemReadM && !hit ? '0 : cnt_q;
        tv_we   = bus.MemReadM && !hit;
      end
      REFILL: begin
        stall        = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {tag, idx, cnt_q, 2'b00};
        we           = bus.mem_ack;
        w_off        = cnt_q;
        w_data       = bus.mem_rdata;
        cnt_d        = bus.mem_ack ? cnt_q + OW'(1) : cnt_q;
        tv_we        = bus.mem_ack && &cnt_q;
        tv_valid     = 1'b1;
        state_d      = bus.mem_ack && &cnt_q ? RESPOND : REFILL;
      end
      WRITE: begin
        stall         = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {bus.ALUResult[WORD_W-1:2], 2'b00};
        bus.mem_wdata = bus.WriteData;
        we            = bus.mem_ack && hit;
        state_d       = bus.mem_ack ? RESPOND : WRITE;
      end
      RESPOND: state_d = IDLE;
    endcase
  end
`ifdef DCACHE_PERF_EN
  logic [WORD_W-1:0] hit_cnt_q, miss_cnt_q;
  logic              rd_idle;
  assign rd_idle = state_q == IDLE && bus.MemReadM;
  always_ff @(posedge clk)
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_q + WORD_W'(rd_idle && hit);
      miss_cnt_q <= miss_cnt_q + WORD_W'(rd_idle && !hit);
    end
  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed plus randomized checks of dcache against a flat memory/tag reference model.
module tb_dcache;
  import dcache_pkg::*;
  localparam int LINES = 16;
  localparam int LW = 4;
  localparam int OW = $clog2(LW);
  localparam int IW = $clog2(LINES);
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  dcache_if bus();
`ifdef DCACHE_PERF_EN
  logic [31:0] hc, mc;
`endif
  dcache #(.LINES(LINES), .LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
`ifdef DCACHE_PERF_EN
    , .HitCount(hc), .MissCount(mc)
`endif
  );
  int nchk = 0;
  int nerr = 0;
  logic [31:0] store [logic [31:0]];
  int rd_acks = 0;
  int wr_acks = 0;
  logic [31:0] rd_q [$];
  logic [31:0] last_waddr, last_wdata;
  int ack_pct = 100;
  logic stray = 1'b0;
  bit mvalid [LINES];
  logic [31:0] mtag [LINES];
  int exp_hits = 0;
  int exp_misses = 0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return store.exists(w) ? store[w] : 32'hA0 + ((w - 32'h100) >> 2);
  endfunction

  // backing memory: answers within the request cycle with probability ack_pct
  always @(posedge clk) begin
    #2;
    bus.mem_ack = stray || (bus.mem_req && int'($urandom_range(1, 100)) <= ack_pct);
    bus.mem_rdata = bus.mem_req ? mem_val(bus.mem_addr) : $urandom;
  end
  always @(negedge clk)
    if (bus.mem_ack && bus.mem_req) begin
      if (bus.mem_we) begin
        store[bus.mem_addr] = bus.mem_wdata;
        last_waddr = bus.mem_addr;
        last_wdata = bus.mem_wdata;
        wr_acks++;
      end else begin
        rd_acks++;
        rd_q.push_back(bus.mem_addr);
      end
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output int racks, output int wacks);
    int r0, w0;
    @(posedge clk); #1;
    bus.MemReadM = !is_wr;
    bus.MemWriteM = is_wr;
    bus.ALUResult = a;
    bus.WriteData = d;
    rd_q.delete();
    r0 = rd_acks;
    w0 = wr_acks;
    stalls = 0;
    forever begin
      @(negedge clk); #1;
      if (!bus.StallM) break;
      stalls++;
      if (stalls > 400) begin
        chk("stall_timeout", stalls, 0);
        break;
      end
    end
    racks = rd_acks - r0;
    wacks = wr_acks - w0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.MemReadM = 1'b0;
    bus.MemWriteM = 1'b0;
  endtask

  task automatic load(input logic [31:0] a);
    int st, ra, wa, idx, pct;
    logic [31:0] tag, exp, base;
    bit hit;
    idx = int'((a >> (2 + OW)) % LINES);
    tag = a >> (2 + OW + IW);
    base = (a >> (2 + OW)) << (2 + OW);
    hit = mvalid[idx] && mtag[idx] == tag;
    exp = mem_val(a);
    pct = ack_pct;
    run_op(1'b0, a, 32'h0, st, ra, wa);
    chk("load_data", bus.ReadData, exp);
    chk("load_req_at_release", bus.mem_req, 0);
    chk("load_read_words", ra, hit ? 0 : LW);
    chk("load_write_words", wa, 0);
    if (hit) chk("hit_stall", st, 0);
    else if (pct == 100) chk("miss_stall", st, LW + 1);
    else chk("miss_stall_min", st >= LW + 1, 1);
    if (!hit)
      for (int k = 0; k < LW && k < rd_q.size(); k++) chk("refill_addr", rd_q[k], base + 32'(4 * k));
    if (hit) exp_hits++;
    else begin
      exp_misses++;
      mvalid[idx] = 1'b1;
      mtag[idx] = tag;
    end
  endtask

  task automatic store_op(input logic [31:0] a, input logic [31:0] d);
    int st, ra, wa, pct;
    pct = ack_pct;
    run_op(1'b1, a, d, st, ra, wa);
    chk("store_write_words", wa, 1);
    chk("store_read_words", ra, 0);
    chk("store_addr", last_waddr, {a[31:2], 2'b00});
    chk("store_data", last_wdata, d);
    chk("store_req_at_release", bus.mem_req, 0);
    if (pct == 100) chk("store_stall", st, 2);
    else chk("store_stall_min", st >= 2, 1);
  endtask

  initial begin
    int r0, cyc;
    logic [31:0] a;
    bus.MemReadM = 1'b0;
    bus.MemWriteM = 1'b0;
    bus.ALUResult = 32'h0;
    bus.WriteData = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    bus.MemReadM = 1'b1;
    bus.ALUResult = 32'h300;
    @(negedge clk);
    chk("reset_stall", bus.StallM, 0);
    chk("reset_req", bus.mem_req, 0);
    chk("reset_we", bus.mem_we, 0);
    chk("reset_addr", bus.mem_addr, 0);
    chk("reset_wdata", bus.mem_wdata, 0);
`ifdef DCACHE_PERF_EN
    chk("reset_hitcount", hc, 0);
    chk("reset_misscount", mc, 0);
`endif
    @(posedge clk); #1;
    bus.MemReadM = 1'b0;
    reset = 1'b1;
    ack_pct = 100;
    load(32'h100);
    load(32'h108);
    store_op(32'h104, 32'hDEAD);
    load(32'h104);
    load(32'h100 + LINES * LW * 4);
    load(32'h100);
    store_op(32'h200, 32'h1234_5678);
    load(32'h200);
    // abort a refill after its second word
    @(posedge clk); #1;
    bus.MemReadM = 1'b1;
    bus.MemWriteM = 1'b0;
    bus.ALUResult = 32'h100;
    r0 = rd_acks;
    cyc = 0;
    while (rd_acks - r0 < 2 && cyc < 50) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("abort_two_acks", rd_acks - r0 >= 2, 1);
    reset = 1'b0;
    ack_pct = 0;
    @(posedge clk); #1;
    bus.MemReadM = 1'b0;
    @(negedge clk);
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    chk("abort_req", bus.mem_req, 0);
    chk("abort_stall", bus.StallM, 0);
`ifdef DCACHE_PERF_EN
    chk("abort_hitcount", hc, 0);
    chk("abort_misscount", mc, 0);
`endif
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    @(negedge clk);
    chk("stray_state", 32'(dut.state_q), 32'(IDLE));
    chk("stray_req", bus.mem_req, 0);
    chk("stray_stall", bus.StallM, 0);
    ack_pct = 100;
    load(32'h100);
    load(32'h10C);
    for (int i = 0; i < 80; i++) begin
      ack_pct = $urandom_range(0, 3) == 0 ? 100 : int'($urandom_range(30, 100));
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) store_op(a, $urandom);
      else load(a);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    @(negedge clk);
`ifdef DCACHE_PERF_EN
    chk("final_hitcount", hc, exp_hits);
    chk("final_misscount", mc, exp_misses);
`endif
    chk("final_stall", bus.StallM, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
